// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator driving a word-wide memory, sub-word stores by read-modify-write
module mem_access_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rw,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   typedef enum logic [2:0] {IDLE, RD, RMW, WR, RESP} state_t;
   state_t            r_state;
   logic              r_ready, r_valid, r_err, r_in_wr, r_signed;
   logic [DATA_W-1:0] r_rdata, r_mem_wdata;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [1:0]        r_lane, r_size;
   logic [15:0]       r_wdata;
   logic              w_err;
   logic [4:0]        w_bsh, w_hsh;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [DATA_W-1:0] w_ext, w_mask, w_ins, w_merged;
   assign req_ready  = r_ready;
   assign resp_valid = r_valid;
   assign resp_err   = r_err;
   assign resp_rdata = r_rdata;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   // a write already scheduled for this edge is dropped if reset is asserted
   assign mem_rw     = r_in_wr & Resetn;
   assign w_err = (req_size == 2'b11) | (req_size == 2'b01 & req_addr[0]) |
                  (req_size == 2'b10 & |req_addr[1:0]);
   assign w_bsh  = {r_lane, 3'b000};
   assign w_hsh  = {r_lane[1], 4'b0000};
   assign w_byte = 8'(mem_rdata >> w_bsh);
   assign w_half = 16'(mem_rdata >> w_hsh);
   always_comb begin
      w_ext    = (r_size == 2'b00) ? {{(DATA_W-8){r_signed & w_byte[7]}}, w_byte} :
                 (r_size == 2'b01) ? {{(DATA_W-16){r_signed & w_half[15]}}, w_half} : mem_rdata;
      w_mask   = (r_size == 2'b00) ? DATA_W'(32'hFF) << w_bsh : DATA_W'(32'hFFFF) << w_hsh;
      w_ins    = (r_size == 2'b00) ? DATA_W'(r_wdata[7:0]) << w_bsh : DATA_W'(r_wdata) << w_hsh;
      w_merged = (mem_rdata & ~w_mask) | w_ins;
   end
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         r_state     <= IDLE;
         r_ready     <= 1'b1;
         r_valid     <= 1'b0;
         r_err       <= 1'b0;
         r_in_wr     <= 1'b0;
         r_rdata     <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_lane      <= '0;
         r_size      <= '0;
         r_signed    <= 1'b0;
         r_wdata     <= '0;
      end else begin
         case (r_state)
            IDLE: if (req_valid) begin
               r_lane   <= req_addr[1:0];
               r_size   <= req_size;
               r_signed <= req_signed;
               r_wdata  <= req_wdata[15:0];
               r_ready  <= 1'b0;
               if (w_err) begin
                  r_state <= RESP;
                  r_valid <= 1'b1;
                  r_err   <= 1'b1;
               end else begin
                  r_mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                  if (!req_we) r_state <= RD;
                  else if (req_size == 2'b10) begin
                     r_state     <= WR;
                     r_in_wr     <= 1'b1;
                     r_mem_wdata <= req_wdata;
                  end else r_state <= RMW;
               end
            end
            RD: begin
               r_state    <= RESP;
               r_rdata    <= w_ext;
               r_valid    <= 1'b1;
               r_mem_addr <= '0;
            end
            RMW: begin
               r_state     <= WR;
               r_mem_wdata <= w_merged;
               r_in_wr     <= 1'b1;
            end
            WR: begin
               r_state     <= RESP;
               r_in_wr     <= 1'b0;
               r_valid     <= 1'b1;
               r_mem_addr  <= '0;
               r_mem_wdata <= '0;
            end
            RESP: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
               r_valid <= 1'b0;
               r_err   <= 1'b0;
               r_rdata <= '0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random load/store checks against a byte-level reference model
module tb_mem_access_unit;
   logic        Clock = 0, Resetn = 0, req_valid = 0, req_we = 0, req_signed = 0, load_ram = 1;
   logic [1:0]  req_size = 0;
   logic [31:0] req_addr = 0, req_wdata = 0;
   logic        req_ready, resp_valid, resp_err, mem_rw;
   logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [31:0] ram [32];
   logic [31:0] mref [32];
   logic [31:0] last_waddr = 0, last_wdata = 0;
   int          vectors = 0, miscompares = 0, wr_count = 0, rv_count = 0;

   mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .Clock(Clock), .Resetn(Resetn), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 Clock = ~Clock;
   assign mem_rdata = ram[mem_addr[6:2]];

   always @(posedge Clock) begin
      if (load_ram) begin
         for (int i = 0; i < 32; i++) ram[i] <= 32'(i * i);
      end else if (mem_rw) begin
         ram[mem_addr[6:2]] <= mem_wdata;
         wr_count <= wr_count + 1;
         last_waddr <= mem_addr;
         last_wdata <= mem_wdata;
      end
      if (resp_valid) rv_count <= rv_count + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] get_byte(input logic [31:0] a);
      return 8'(mref[a[6:2]] >> (8 * a[1:0]));
   endfunction

   function automatic void set_byte(input logic [31:0] a, input logic [7:0] b);
      mref[a[6:2]] = (mref[a[6:2]] & ~(32'hFF << (8 * a[1:0]))) | (32'(b) << (8 * a[1:0]));
   endfunction

   // little-endian byte view of memory; stores update the model as they are predicted
   function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rd, output logic e, output int lat, output int nwr);
      int n;
      logic [31:0] v;
      e = (size == 3) || (size == 1 && addr[0]) || (size == 2 && addr[1:0] != 0);
      rd = 0; nwr = 0; lat = 1;
      if (e) return;
      n = 1 << size;
      if (!we) begin
         v = 0;
         for (int k = 0; k < n; k++) v = v | (32'(get_byte(addr + k)) << (8 * k));
         if (sgn && n < 4 && v[8 * n - 1]) v = v | (32'hFFFFFFFF << (8 * n));
         rd = v; lat = 2;
      end else begin
         for (int k = 0; k < n; k++) set_byte(addr + k, 8'(wdata >> (8 * k)));
         lat = (n == 4) ? 2 : 3;
         nwr = 1;
      end
   endfunction

   task automatic txn(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] erd;
      logic ee;
      int elat, enwr, lat, w0, r0;
      int n = 0;
      while (!req_ready && n < 20) begin @(negedge Clock); n++; end
      chk({tag, " ready"}, 32'(req_ready), 1);
      chk({tag, " idle bus"}, mem_addr | mem_wdata, 0);
      model(we, size, sgn, addr, wdata, erd, ee, elat, enwr);
      w0 = wr_count; r0 = rv_count;
      req_valid = 1; req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
      @(negedge Clock);
      req_valid = 0;
      lat = 1;
      while (!resp_valid && lat < 10) begin @(negedge Clock); lat++; end
      chk({tag, " latency"}, lat, elat);
      chk({tag, " rdata"}, resp_rdata, erd);
      chk({tag, " err"}, 32'(resp_err), 32'(ee));
      @(negedge Clock);
      chk({tag, " writes"}, wr_count - w0, enwr);
      chk({tag, " resp pulses"}, rv_count - r0, 1);
      chk({tag, " mem word"}, ram[addr[6:2]], mref[addr[6:2]]);
      if (enwr != 0) chk({tag, " waddr"}, last_waddr, {addr[31:2], 2'b00});
   endtask

   initial begin
      logic [31:0] qa [3];
      logic [31:0] qexp [3];
      logic [31:0] d;
      logic e;
      int l, nw, w0, r0, idx, cyc;
      bit pend;
      int rc [$];
      logic [31:0] rdq [$];
      for (int i = 0; i < 32; i++) mref[i] = 32'(i * i);
      repeat (3) @(negedge Clock);
      load_ram = 0;
      Resetn = 1;
      @(negedge Clock);
      chk("rst resp_valid", 32'(resp_valid), 0);
      chk("rst resp_err", 32'(resp_err), 0);
      chk("rst resp_rdata", resp_rdata, 0);
      chk("rst mem_rw", 32'(mem_rw), 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst mem_wdata", mem_wdata, 0);
      chk("rst req_ready", 32'(req_ready), 1);

      txn("word ld 14", 0, 2'b10, 0, 32'h14, 0);
      chk("word ld 14 model", mref[5], 32'h19);
      txn("byte ld 3C s", 0, 2'b00, 1, 32'h3C, 0);
      txn("byte ld 3C u", 0, 2'b00, 0, 32'h3C, 0);
      txn("half st 0E", 1, 2'b01, 0, 32'h0E, 32'h0000BEEF);
      chk("half st data", last_wdata, 32'hBEEF0009);
      txn("word ld 0C", 0, 2'b10, 0, 32'h0C, 0);
      txn("misalign ld", 0, 2'b10, 0, 32'h06, 0);
      txn("size11 st", 1, 2'b11, 0, 32'h10, 32'h12345678);
      txn("half misalign", 0, 2'b01, 1, 32'h21, 0);

      w0 = wr_count; r0 = rv_count;
      req_valid = 1; req_we = 1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
      @(negedge Clock);
      req_valid = 0;
      chk("rst-in-WR rw before", 32'(mem_rw), 1);
      Resetn = 0;
      #1;
      chk("rst-in-WR rw gated", 32'(mem_rw), 0);
      @(negedge Clock);
      Resetn = 1;
      @(negedge Clock);
      chk("rst-in-WR ready", 32'(req_ready), 1);
      chk("rst-in-WR ram8", ram[8], 32'd64);
      chk("rst-in-WR writes", wr_count - w0, 0);
      chk("rst-in-WR resp", rv_count - r0, 0);
      txn("ld after rst", 0, 2'b10, 0, 32'h20, 0);

      qa[0] = 32'h04; qa[1] = 32'h08; qa[2] = 32'h40;
      for (int i = 0; i < 3; i++) model(0, 2'b10, 0, qa[i], 0, qexp[i], e, l, nw);
      r0 = rv_count;
      idx = 0; cyc = 0;
      req_we = 0; req_size = 2'b10; req_signed = 0; req_addr = qa[0]; req_valid = 1;
      pend = req_ready;
      for (int c = 0; c < 15; c++) begin
         @(negedge Clock);
         cyc++;
         if (pend) begin
            idx++;
            if (idx < 3) req_addr = qa[idx];
            else req_valid = 0;
         end
         if (resp_valid) begin rc.push_back(cyc); rdq.push_back(resp_rdata); end
         pend = req_valid && req_ready;
      end
      chk("queue count", rc.size(), 3);
      chk("queue pulses", rv_count - r0, 3);
      for (int i = 0; i < rc.size() && i < 3; i++) begin
         chk($sformatf("queue data %0d", i), rdq[i], qexp[i]);
         if (i == 0) chk("queue first lat", rc[0], 2);
         else chk($sformatf("queue spacing %0d", i), rc[i] - rc[i-1], 3);
      end

      for (int t = 0; t < 60; t++) begin
         logic [1:0] sz;
         logic [31:0] a;
         sz = 2'($urandom_range(0, 3));
         a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 127));
         if ($urandom_range(0, 1) == 1 && sz != 3) a = a & ~((32'd1 << sz) - 1);
         txn($sformatf("rand %0d", t), 1'($urandom), sz, 1'($urandom), a, $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
